// File: rtl/soc_cpu_debug_mem_arbiter.sv
// Debug-memory arbiter: one synchronous RAM port shared by a JTAG debug monitor and an Avalon-MM slave.
// Define DEBUG_ARB_JTAG_PRIORITY_EN for fixed JTAG tie priority instead of round-robin.
module soc_cpu_debug_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_req,
  input  logic              jtag_write,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic              monitor_error_clr,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [ADDR_W-1:0] av_address,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, GRANT, RDWAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic              grant_j_q, grant_j_d;
  logic              pend_j_q, pend_j_d;
  logic              jtag_we_q, jtag_we_d;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic [DATA_W-1:0] jtag_wdata_q, jtag_wdata_d;
  logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
  logic [DATA_W-1:0] av_rdata_q, av_rdata_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
`ifndef DEBUG_ARB_JTAG_PRIORITY_EN
  logic              last_j_q, last_j_d;
`endif

  logic gnt_we, j_done, j_accept, j_overrun, j_pend, av_pend, tie_j;

  // A strobe landing in the JTAG completion cycle is a fresh request, not an overrun.
  always_comb begin
    gnt_we    = grant_j_q ? jtag_we_q : av_write;
    j_done    = grant_j_q && (((state_q == GRANT) && gnt_we) || (state_q == RDWAIT));
    j_accept  = jtag_req && (!pend_j_q || j_done);
    j_overrun = jtag_req && pend_j_q && !j_done;
    j_pend    = pend_j_q || j_accept;
    av_pend   = (av_read || av_write) && ((state_q == IDLE) || grant_j_q);
`ifdef DEBUG_ARB_JTAG_PRIORITY_EN
    tie_j     = 1'b1;
`else
    tie_j     = !last_j_q;
`endif

    pend_j_d     = pend_j_q;
    jtag_we_d    = jtag_we_q;
    jtag_addr_d  = jtag_addr_q;
    jtag_wdata_d = jtag_wdata_q;
    ready_d      = ready_q;
    error_d      = error_q;
    if (j_done) begin
      pend_j_d = 1'b0;
      ready_d  = 1'b1;
    end
    if (j_accept) begin
      pend_j_d     = 1'b1;
      ready_d      = 1'b0;
      jtag_we_d    = jtag_write;
      jtag_addr_d  = jtag_addr;
      jtag_wdata_d = jtag_wdata;
    end
    if (j_overrun)
      error_d = 1'b1;
    else if (monitor_error_clr)
      error_d = 1'b0;
  end

  // The last-grant bit only moves on contended arbitrations, so it records who won the last tie.
  always_comb begin
    state_d        = state_q;
    grant_j_d      = grant_j_q;
`ifndef DEBUG_ARB_JTAG_PRIORITY_EN
    last_j_d       = last_j_q;
`endif
    mon_dreg_d     = mon_dreg_q;
    av_rdata_d     = av_rdata_q;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    av_waitrequest = 1'b1;
    av_readdata    = '0;
    case (state_q)
      IDLE: begin
        if (j_pend && av_pend) begin
          grant_j_d = tie_j;
`ifndef DEBUG_ARB_JTAG_PRIORITY_EN
          last_j_d  = tie_j;
`endif
          state_d   = GRANT;
        end else if (j_pend) begin
          grant_j_d = 1'b1;
          state_d   = GRANT;
        end else if (av_pend) begin
          grant_j_d = 1'b0;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        mem_addr  = grant_j_q ? jtag_addr_q : av_address;
        mem_wdata = grant_j_q ? jtag_wdata_q : av_writedata;
        mem_we    = gnt_we;
        mem_re    = !gnt_we;
        if (!grant_j_q && gnt_we)
          av_waitrequest = 1'b0;
        state_d = gnt_we ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        if (grant_j_q)
          mon_dreg_d = mem_rdata;
        else
          av_rdata_d = mem_rdata;
        state_d = DONE;
      end
      DONE: begin
        if (!grant_j_q) begin
          av_waitrequest = 1'b0;
          av_readdata    = av_rdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_j_q    <= 1'b0;
      pend_j_q     <= 1'b0;
      jtag_we_q    <= 1'b0;
      jtag_addr_q  <= '0;
      jtag_wdata_q <= '0;
      mon_dreg_q   <= '0;
      av_rdata_q   <= '0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
`ifndef DEBUG_ARB_JTAG_PRIORITY_EN
      last_j_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_j_q    <= grant_j_d;
      pend_j_q     <= pend_j_d;
      jtag_we_q    <= jtag_we_d;
      jtag_addr_q  <= jtag_addr_d;
      jtag_wdata_q <= jtag_wdata_d;
      mon_dreg_q   <= mon_dreg_d;
      av_rdata_q   <= av_rdata_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
`ifndef DEBUG_ARB_JTAG_PRIORITY_EN
      last_j_q     <= last_j_d;
`endif
    end
  end

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule
